// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//
// Writes one switch-selected byte into an external memory word for each
// debounced press of a pushbutton. The raw button is synchronised, debounced,
// turned into a single write handshake (mem_we held until mem_ack or a
// timeout), and then the button must be released and stay released before
// another press is accepted.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a press or
//                     a release
//   ACK_TIMEOUT     : cycles to wait for mem_ack before abandoning a write
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous, active-high reset
//   btn_write    in   raw, bouncing pushbutton (active high)
//   sw_addr[8:0] in   switch-selected word address
//   sw_data[7:0] in   switch-selected data byte
//   mem_ack      in   memory accepts the write when high while mem_we is high
//   mem_we       out  write request, held until ack or timeout
//   mem_addr     out  write address, frozen for the whole write
//   mem_wdata    out  write data {24'h0, byte}, frozen for the whole write
//   busy         out  high whenever the FSM is not idle
//   write_count  out  number of acknowledged writes (wraps 255 -> 0)
//   err          out  sticky ack-timeout flag, cleared only by reset
//
// Build option
//   MEM_LOADER_AUTOINC_EN : when defined, mem_addr comes from an internal
//   9-bit pointer that reloads from sw_addr whenever the switches change
//   while idle and advances after every acknowledged write. When undefined,
//   mem_addr is simply sw_addr captured at the start of each write.
// -----------------------------------------------------------------------------
module mem_loader #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACK_TIMEOUT     = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_write,
    input  logic [8:0]  sw_addr,
    input  logic [7:0]  sw_data,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic [7:0]  write_count,
    output logic        err
);

    // Counter widths sized so the terminal values (N-1) always fit.
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [DEB_W-1:0] DEB_ZERO = DEB_W'(0);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_ZERO  = TO_W'(0);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_WRITE    = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              btn_meta_q, btn_meta_d;
    logic              btn_sync_q, btn_sync_d;
    logic              btn_s;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [8:0]        mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic [7:0]        write_count_q, write_count_d;
    logic              err_q, err_d;
`ifdef MEM_LOADER_AUTOINC_EN
    logic [8:0]        ptr_q, ptr_d;
    logic [8:0]        last_sw_q, last_sw_d;
`endif

    // The FSM only ever looks at the second synchroniser stage.
    assign btn_s = btn_sync_q;

    // Next-state, counter, handshake and capture logic.
    always_comb begin
        btn_meta_d    = btn_write;
        btn_sync_d    = btn_meta_q;
        state_d       = state_q;
        deb_cnt_d     = deb_cnt_q;
        to_cnt_d      = to_cnt_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        write_count_d = write_count_q;
        err_d         = err_q;
`ifdef MEM_LOADER_AUTOINC_EN
        ptr_d         = ptr_q;
        last_sw_d     = last_sw_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef MEM_LOADER_AUTOINC_EN
                // Switch movement while idle re-targets the pointer.
                if (sw_addr != last_sw_q) begin
                    ptr_d     = sw_addr;
                    last_sw_d = sw_addr;
                end else begin
                    ptr_d     = ptr_q;
                    last_sw_d = last_sw_q;
                end
`endif
                if (btn_s) begin
                    state_d   = ST_DEBOUNCE;
                    deb_cnt_d = DEB_ZERO;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_DEBOUNCE: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    // Press accepted: freeze address and data for this write.
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    to_cnt_d    = TO_ZERO;
`ifdef MEM_LOADER_AUTOINC_EN
                    mem_addr_d  = ptr_q;
`else
                    mem_addr_d  = sw_addr;
`endif
                    mem_wdata_d = {24'h000000, sw_data};
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end

            ST_WRITE: begin
                if (mem_ack) begin
                    state_d       = ST_RELEASE;
                    mem_we_d      = 1'b0;
                    deb_cnt_d     = DEB_ZERO;
                    write_count_d = write_count_q + 8'd1;
`ifdef MEM_LOADER_AUTOINC_EN
                    ptr_d         = ptr_q + 9'd1;
`endif
                end else if (to_cnt_q == TO_LAST) begin
                    // Abandon the write; the count and pointer stay put.
                    state_d   = ST_RELEASE;
                    mem_we_d  = 1'b0;
                    deb_cnt_d = DEB_ZERO;
                    err_d     = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
                end
            end

            ST_RELEASE: begin
                // Any high sample restarts the release qualification.
                if (btn_s) begin
                    deb_cnt_d = DEB_ZERO;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                mem_we_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces everything idle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q    <= 1'b0;
            btn_sync_q    <= 1'b0;
            state_q       <= ST_IDLE;
            deb_cnt_q     <= DEB_ZERO;
            to_cnt_q      <= TO_ZERO;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 9'd0;
            mem_wdata_q   <= 32'd0;
            busy_q        <= 1'b0;
            write_count_q <= 8'd0;
            err_q         <= 1'b0;
`ifdef MEM_LOADER_AUTOINC_EN
            ptr_q         <= 9'd0;
            last_sw_q     <= 9'd0;
`endif
        end else begin
            btn_meta_q    <= btn_meta_d;
            btn_sync_q    <= btn_sync_d;
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            to_cnt_q      <= to_cnt_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            busy_q        <= busy_d;
            write_count_q <= write_count_d;
            err_q         <= err_d;
`ifdef MEM_LOADER_AUTOINC_EN
            ptr_q         <= ptr_d;
            last_sw_q     <= last_sw_d;
`endif
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;
    assign write_count = write_count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
//
// Directed, self-checking bench for mem_loader with DEBOUNCE_CYCLES=4 and
// ACK_TIMEOUT=8. Inputs change 2 time units after a rising edge; outputs are
// read at the same point. A small negedge monitor records every mem_we pulse
// (count, length, address and data at its start).
// -----------------------------------------------------------------------------
module tb_mem_loader;

    localparam int DEB = 4;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_write;
    logic [8:0]  sw_addr;
    logic [7:0]  sw_data;
    logic        mem_ack;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic [7:0]  write_count;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    int          pulses   = 0;
    int          cur_len  = 0;
    int          last_len = 0;
    logic        we_prev  = 1'b0;
    logic [8:0]  pulse_addr = 9'd0;
    logic [31:0] pulse_data = 32'd0;

    mem_loader #(
        .DEBOUNCE_CYCLES (DEB),
        .ACK_TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_write   (btn_write),
        .sw_addr     (sw_addr),
        .sw_data     (sw_data),
        .mem_ack     (mem_ack),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .write_count (write_count),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: records each mem_we pulse's length and start values.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (we_prev !== 1'b1) begin
                pulses     = pulses + 1;
                cur_len    = 1;
                pulse_addr = mem_addr;
                pulse_data = mem_wdata;
            end else begin
                cur_len = cur_len + 1;
            end
        end else if (we_prev === 1'b1) begin
            last_len = cur_len;
        end
        we_prev = mem_we;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Press (and keep holding) the button, then ack on WRITE cycle ack_at
    // (0 = never). lat = ticks from press to mem_we seen, len = pulse length.
    task automatic do_write(input int ack_at, output int lat, output int len);
        lat = -1;
        len = 0;
        btn_write = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (mem_we === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat > 0) begin
            len = 1;
            for (int j = 0; j < 40; j++) begin
                if (len == ack_at) mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
                if (mem_we === 1'b1) len = len + 1;
                else break;
            end
        end
    endtask

    // Release the button and wait (bounded) for the FSM to return idle.
    task automatic release_wait(output bit ok);
        ok = 1'b0;
        btn_write = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; btn_write = 1'b0; mem_ack = 1'b0;
        sw_addr = 9'd0; sw_data = 8'h00;
        repeat (3) tick();
        n_total++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %b want 0", mem_we); else n_pass++;
        n_total++; if (mem_addr !== 9'd0) $display("FAIL reset_addr: got %0d want 0", mem_addr); else n_pass++;
        n_total++; if (mem_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (write_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", write_count); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        int lat, len, p0;
        bit ok;
        sw_addr = 9'd5; sw_data = 8'h2A;
        p0 = pulses;
        do_write(3, lat, len);
        tick();
        // 2 synchroniser edges + 1 idle edge + 4 debounce edges
        n_total++; if (lat !== 7) $display("FAIL basic_latency: got %0d want 7", lat); else n_pass++;
        n_total++; if (len !== 3) $display("FAIL basic_len: got %0d want 3", len); else n_pass++;
        n_total++; if (last_len !== 3) $display("FAIL basic_mon_len: got %0d want 3", last_len); else n_pass++;
        n_total++; if (pulse_addr !== 9'd5) $display("FAIL basic_addr: got %0d want 5", pulse_addr); else n_pass++;
        n_total++; if (pulse_data !== 32'h0000002A) $display("FAIL basic_data: got %h want 0000002a", pulse_data); else n_pass++;
        n_total++; if (write_count !== 8'd1) $display("FAIL basic_count: got %0d want 1", write_count); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else n_pass++;
        release_wait(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL basic_idle: got %b want 1", ok); else n_pass++;
        n_total++; if (pulses - p0 !== 1) $display("FAIL basic_pulses: got %0d want 1", pulses - p0); else n_pass++;
    endtask

    task automatic test_bounce;
        logic [4:0] pat;
        bit bounce_we, got, ok;
        int p0;
        pat = 5'b01101;          // applied LSB first: 1,0,1,1,0
        p0 = pulses;
        bounce_we = 1'b0;
        got = 1'b0;
        mem_ack = 1'b1;          // ack outside WRITE must be ignored
        for (int i = 0; i < 5; i++) begin
            btn_write = pat[i];
            tick();
            if (mem_we === 1'b1) bounce_we = 1'b1;
        end
        btn_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_we === 1'b1) got = 1'b1;
        end
        mem_ack = 1'b0;
        repeat (20) tick();      // still held: no second write
        n_total++; if (bounce_we !== 1'b0) $display("FAIL bounce_no_we: got %b want 0", bounce_we); else n_pass++;
        n_total++; if (got !== 1'b1) $display("FAIL bounce_write_seen: got %b want 1", got); else n_pass++;
        n_total++; if (pulses - p0 !== 1) $display("FAIL bounce_pulses: got %0d want 1", pulses - p0); else n_pass++;
        n_total++; if (last_len !== 1) $display("FAIL bounce_len: got %0d want 1", last_len); else n_pass++;
        n_total++; if (write_count !== 8'd2) $display("FAIL bounce_count: got %0d want 2", write_count); else n_pass++;
        release_wait(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL bounce_idle: got %b want 1", ok); else n_pass++;
        n_total++; if (pulses - p0 !== 1) $display("FAIL bounce_pulses_after: got %0d want 1", pulses - p0); else n_pass++;
    endtask

    task automatic test_timeout;
        int lat, len, p0;
        bit ok;
        p0 = pulses;
        do_write(0, lat, len);
        tick();
        n_total++; if (len !== 8) $display("FAIL timeout_len: got %0d want 8", len); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL timeout_we: got %b want 0", mem_we); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err); else n_pass++;
        n_total++; if (write_count !== 8'd2) $display("FAIL timeout_count: got %0d want 2", write_count); else n_pass++;
        n_total++; if (pulses - p0 !== 1) $display("FAIL timeout_pulses: got %0d want 1", pulses - p0); else n_pass++;
        release_wait(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL timeout_idle: got %b want 1", ok); else n_pass++;
        do_write(1, lat, len);
        release_wait(ok);
        n_total++; if (write_count !== 8'd3) $display("FAIL timeout_next_count: got %0d want 3", write_count); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL timeout_err_sticky: got %b want 1", err); else n_pass++;
    endtask

    task automatic test_data_hold;
        bit got, ok;
        got = 1'b0;
        sw_data = 8'h11; sw_addr = 9'd100;
        btn_write = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_we === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_total++; if (got !== 1'b1) $display("FAIL hold_write_seen: got %b want 1", got); else n_pass++;
        sw_data = 8'h22; sw_addr = 9'd200;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (mem_wdata !== 32'h00000011) $display("FAIL hold_wdata: got %h want 00000011", mem_wdata); else n_pass++;
            n_total++; if (mem_addr !== 9'd100) $display("FAIL hold_addr: got %0d want 100", mem_addr); else n_pass++;
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_total++; if (mem_we !== 1'b0) $display("FAIL hold_we_drop: got %b want 0", mem_we); else n_pass++;
        n_total++; if (write_count !== 8'd4) $display("FAIL hold_count: got %0d want 4", write_count); else n_pass++;
        release_wait(ok);
        n_total++; if (ok !== 1'b1) $display("FAIL hold_idle: got %b want 1", ok); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [8:0] exp_addr [3];
        int lat, len;
        bit ok, all_ok;
`ifdef MEM_LOADER_AUTOINC_EN
        exp_addr[0] = 9'd511; exp_addr[1] = 9'd0; exp_addr[2] = 9'd1;
`else
        exp_addr[0] = 9'd511; exp_addr[1] = 9'd511; exp_addr[2] = 9'd511;
`endif
        all_ok = 1'b1;
        sw_addr = 9'd511; sw_data = 8'h5A;
        for (int w = 0; w < 3; w++) begin
            do_write(2, lat, len);
            tick();
            n_total++; if (pulse_addr !== exp_addr[w]) $display("FAIL wrap_addr%0d: got %0d want %0d", w, pulse_addr, exp_addr[w]); else n_pass++;
            release_wait(ok);
            if (ok !== 1'b1) all_ok = 1'b0;
        end
        n_total++; if (all_ok !== 1'b1) $display("FAIL wrap_idle: got %b want 1", all_ok); else n_pass++;
        n_total++; if (write_count !== 8'd7) $display("FAIL wrap_count: got %0d want 7", write_count); else n_pass++;
    endtask

    task automatic test_reset_write;
        bit got;
        got = 1'b0;
        sw_addr = 9'd33; sw_data = 8'h77;
        btn_write = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_we === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_total++; if (got !== 1'b1) $display("FAIL rstw_write_seen: got %b want 1", got); else n_pass++;
        tick();                  // now in the 2nd WRITE cycle
        reset = 1'b1;
        btn_write = 1'b0;
        #1;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rstw_we: got %b want 0", mem_we); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstw_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (mem_addr !== 9'd0) $display("FAIL rstw_addr: got %0d want 0", mem_addr); else n_pass++;
        n_total++; if (mem_wdata !== 32'd0) $display("FAIL rstw_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_total++; if (write_count !== 8'd0) $display("FAIL rstw_count: got %0d want 0", write_count); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL rstw_err: got %b want 0", err); else n_pass++;
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();
        n_total++; if (write_count !== 8'd0) $display("FAIL rstw_count_after: got %0d want 0", write_count); else n_pass++;
        n_total++; if (mem_we !== 1'b0) $display("FAIL rstw_we_after: got %b want 0", mem_we); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rstw_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_timeout();
        test_data_hold();
        test_wrap();
        test_reset_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "time limit");
    end

endmodule
